// File: rtl/rf_writeback.sv
// Register-file write initiator: merges ALU and load results into a small in-order FIFO, one write per cycle.
// Head is visible on the write port the cycle after accept; in_ready drops once fewer than two slots are free.
module rf_writeback #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_rdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  output logic        in_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  input  logic [4:0]  rdAddrA,
  input  logic [4:0]  rdAddrB,
  output logic        pendA,
  output logic        pendB
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] TWO_C   = CNT_W'(2);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wbEntry_t;

  wbEntry_t         entries [DEPTH];
  logic [DEPTH-1:0] entryVld;
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] aluSlot;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] freeSlots;
  logic [CNT_W-1:0] enqCnt;
  logic [CNT_W-1:0] deqCnt;
  logic             ldAcc;
  logic             aluAcc;
  logic             deq;
  logic [31:0]      ldFmt;

  function automatic logic [31:0] fmtLoad(input logic [31:0] word,
                                          input logic [2:0]  funct3,
                                          input logic [1:0]  lo);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'b000:  fmtLoad = {{24{b[7]}}, b};
      3'b100:  fmtLoad = {24'd0, b};
      3'b001:  fmtLoad = {{16{h[15]}}, h};
      3'b101:  fmtLoad = {16'd0, h};
      default: fmtLoad = word;
    endcase
  endfunction

  // Two free slots are always reserved so both producers can land in the same cycle.
  assign freeSlots = DEPTH_C - count;
  assign in_ready  = !reset && (freeSlots >= TWO_C);

  // Writes to x0 are architecturally dead, so they never take a slot.
  assign ldAcc  = ld_valid  && in_ready && (ld_rd  != 5'd0);
  assign aluAcc = alu_valid && in_ready && (alu_rd != 5'd0);

  assign enqCnt  = {{(CNT_W-1){1'b0}}, ldAcc} + {{(CNT_W-1){1'b0}}, aluAcc};
  assign deq     = !reset && (count != '0);
  assign deqCnt  = {{(CNT_W-1){1'b0}}, deq};
  assign aluSlot = ldAcc ? (wrPtr + PTR_W'(1)) : wrPtr;
  assign ldFmt   = fmtLoad(ld_rdata, ld_funct3, ld_addr_lo);

  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      wrPtr    <= '0;
      rdPtr    <= '0;
      entryVld <= '0;
    end else begin
      if (deq) begin
        entryVld[rdPtr] <= 1'b0;
        rdPtr           <= rdPtr + PTR_W'(1);
      end
      if (ldAcc)  entryVld[wrPtr]   <= 1'b1;
      if (aluAcc) entryVld[aluSlot] <= 1'b1;
      wrPtr <= wrPtr + PTR_W'(enqCnt);
      count <= count + enqCnt - deqCnt;
    end
  end

  // The load is older than a same-cycle ALU result, so it takes the lower slot.
  always_ff @(posedge clk) begin
    if (ldAcc)  entries[wrPtr]   <= '{rd: ld_rd,  data: ldFmt};
    if (aluAcc) entries[aluSlot] <= '{rd: alu_rd, data: alu_data};
  end

  assign rf_we    = deq;
  assign rf_waddr = rf_we ? entries[rdPtr].rd   : 5'd0;
  assign rf_wdata = rf_we ? entries[rdPtr].data : 32'd0;

  always_comb begin
    pendA = 1'b0;
    pendB = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entryVld[i] && (entries[i].rd == rdAddrA)) pendA = 1'b1;
      if (entryVld[i] && (entries[i].rd == rdAddrB)) pendB = 1'b1;
    end
    pendA = pendA && !reset && (rdAddrA != 5'd0);
    pendB = pendB && !reset && (rdAddrB != 5'd0);
  end

endmodule

// File: tb/tb_rf_writeback.sv
// Directed bench for rf_writeback: ALU, load formatting, ordering, backpressure, x0 drop, reset flush.
module tb_rf_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_rdata;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic        in_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  rdAddrA;
  logic [4:0]  rdAddrB;
  logic        pendA;
  logic        pendB;

  int nCmp = 0;
  int nErr = 0;

  logic [31:0] rfModel [32] = '{default: 32'd0};

  rf_writeback #(.DEPTH(4), .CNT_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .ld_valid   (ld_valid),
    .ld_rd      (ld_rd),
    .ld_rdata   (ld_rdata),
    .ld_funct3  (ld_funct3),
    .ld_addr_lo (ld_addr_lo),
    .in_ready   (in_ready),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .rdAddrA    (rdAddrA),
    .rdAddrB    (rdAddrB),
    .pendA      (pendA),
    .pendB      (pendB)
  );

  always #5 clk = ~clk;

  // Register file as seen by the core: commits whatever the write port carries.
  always @(posedge clk) begin
    if (rf_we) rfModel[rf_waddr] <= rf_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic setPair(input int k);
    ld_rd     = 5'(10 + k);
    ld_rdata  = 32'h100 + 32'(k);
    ld_funct3 = 3'b010;
    ld_addr_lo = 2'd0;
    alu_rd    = 5'(20 + k);
    alu_data  = 32'h200 + 32'(k);
  endtask

  logic [2:0]  vF3  [9] = '{3'b000, 3'b100, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b011, 3'b001};
  logic [1:0]  vLo  [9] = '{2'd3, 2'd2, 2'd1, 2'd2, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0};
  logic [31:0] vExp [9] = '{32'hFFFFFF80, 32'h000000FF, 32'h0000007F, 32'hFFFF80FF, 32'h00007F01,
                            32'h80FF7F01, 32'h0000007F, 32'h80FF7F01, 32'h00007F01};

  initial begin
    reset = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_rdata = '0; ld_funct3 = '0; ld_addr_lo = '0;
    rdAddrA = 5'd5; rdAddrB = 5'd0;

    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_pendA", 32'(pendA), 32'd0);
    chk("rst_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Single ALU write
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    tick();
    alu_valid = 1'b0;
    chk("alu_we", 32'(rf_we), 32'd1);
    chk("alu_waddr", 32'(rf_waddr), 32'd5);
    chk("alu_wdata", rf_wdata, 32'h00001234);
    chk("alu_pendA", 32'(pendA), 32'd1);
    tick();
    chk("alu_we_after", 32'(rf_we), 32'd0);
    chk("alu_pendA_after", 32'(pendA), 32'd0);
    chk("alu_rf5", rfModel[5], 32'h00001234);

    // Load formatting
    for (int i = 0; i < 9; i++) begin
      ld_valid = 1'b1; ld_rd = 5'd7; ld_rdata = 32'h80FF7F01;
      ld_funct3 = vF3[i]; ld_addr_lo = vLo[i];
      tick();
      ld_valid = 1'b0;
      chk($sformatf("load%0d_we", i), 32'(rf_we), 32'd1);
      chk($sformatf("load%0d_waddr", i), 32'(rf_waddr), 32'd7);
      chk($sformatf("load%0d_wdata", i), rf_wdata, vExp[i]);
      tick();
    end
    chk("load_idle", 32'(rf_we), 32'd0);

    // Same-cycle load and ALU to one register: load is older
    ld_valid = 1'b1; ld_rd = 5'd3; ld_rdata = 32'hAA; ld_funct3 = 3'b010; ld_addr_lo = 2'd0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hBB;
    rdAddrA = 5'd3;
    tick();
    ld_valid = 1'b0; alu_valid = 1'b0;
    chk("same_w1_waddr", 32'(rf_waddr), 32'd3);
    chk("same_w1_wdata", rf_wdata, 32'hAA);
    chk("same_pendA", 32'(pendA), 32'd1);
    tick();
    chk("same_w2_we", 32'(rf_we), 32'd1);
    chk("same_w2_wdata", rf_wdata, 32'hBB);
    tick();
    chk("same_idle", 32'(rf_we), 32'd0);
    chk("same_rf3", rfModel[3], 32'hBB);

    // Back-to-back pairs against a 4-deep queue
    ld_valid = 1'b1; alu_valid = 1'b1; setPair(0); rdAddrB = 5'd22;
    #1;
    chk("bp_rdy0", 32'(in_ready), 32'd1);
    tick();
    chk("bp_e1_waddr", 32'(rf_waddr), 32'd10);
    chk("bp_e1_wdata", rf_wdata, 32'h100);
    chk("bp_e1_rdy", 32'(in_ready), 32'd1);
    setPair(1);
    tick();
    chk("bp_e2_rdy", 32'(in_ready), 32'd0);
    chk("bp_e2_waddr", 32'(rf_waddr), 32'd20);
    chk("bp_e2_wdata", rf_wdata, 32'h200);
    setPair(2); rdAddrB = 5'd12;
    tick();
    chk("bp_e3_rdy", 32'(in_ready), 32'd1);
    chk("bp_e3_waddr", 32'(rf_waddr), 32'd11);
    chk("bp_e3_wdata", rf_wdata, 32'h101);
    chk("bp_e3_pendB", 32'(pendB), 32'd0);
    tick();
    ld_valid = 1'b0; alu_valid = 1'b0; rdAddrB = 5'd22;
    #1;
    chk("bp_e4_rdy", 32'(in_ready), 32'd0);
    chk("bp_e4_waddr", 32'(rf_waddr), 32'd21);
    chk("bp_e4_pendB", 32'(pendB), 32'd1);
    tick();
    chk("bp_e5_waddr", 32'(rf_waddr), 32'd12);
    chk("bp_e5_wdata", rf_wdata, 32'h102);
    chk("bp_e5_rdy", 32'(in_ready), 32'd1);
    tick();
    chk("bp_e6_waddr", 32'(rf_waddr), 32'd22);
    chk("bp_e6_wdata", rf_wdata, 32'h202);
    tick();
    chk("bp_e7_we", 32'(rf_we), 32'd0);
    chk("bp_e7_rdy", 32'(in_ready), 32'd1);
    chk("bp_e7_pendB", 32'(pendB), 32'd0);
    chk("bp_rf10", rfModel[10], 32'h100);
    chk("bp_rf21", rfModel[21], 32'h201);
    chk("bp_rf22", rfModel[22], 32'h202);

    // x0 destinations are dropped
    ld_valid = 1'b1; ld_rd = 5'd0; ld_rdata = 32'hDEAD;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hBEEF;
    rdAddrA = 5'd0;
    tick();
    ld_valid = 1'b0; alu_valid = 1'b0;
    chk("x0_we", 32'(rf_we), 32'd0);
    chk("x0_pendA", 32'(pendA), 32'd0);
    chk("x0_rdy", 32'(in_ready), 32'd1);

    // Reset flushes a partly full queue
    ld_valid = 1'b1; ld_rd = 5'd1; ld_rdata = 32'h11; ld_funct3 = 3'b010;
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h22;
    tick();
    ld_rd = 5'd4; ld_rdata = 32'h44; alu_rd = 5'd6; alu_data = 32'h66;
    tick();
    ld_valid = 1'b0; alu_valid = 1'b0; rdAddrA = 5'd2;
    #1;
    chk("fl_full_pendA", 32'(pendA), 32'd1);
    chk("fl_full_rdy", 32'(in_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("fl_rst_we", 32'(rf_we), 32'd0);
    chk("fl_rst_rdy", 32'(in_ready), 32'd0);
    chk("fl_rst_pendA", 32'(pendA), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("fl_post_rdy", 32'(in_ready), 32'd1);
    chk("fl_post_we", 32'(rf_we), 32'd0);
    chk("fl_post_pendA", 32'(pendA), 32'd0);
    tick();
    chk("fl_later_we", 32'(rf_we), 32'd0);
    chk("fl_rf1", rfModel[1], 32'h11);
    chk("fl_rf2", rfModel[2], 32'h0);
    chk("fl_rf4", rfModel[4], 32'h0);
    chk("fl_rf6", rfModel[6], 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
